// File: rtl/clk_divider_ctrl.sv
// +----------------------------------------------------------------------------+
// | clk_divider_ctrl: programmable clock divider with glitch-free divisor      |
// | switching, stop/start control and a stretched downstream reset.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module clk_divider_ctrl #(
  parameter int DIV_WIDTH       = 8,
  parameter int DEFAULT_DIV     = 2,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_load_i,
  output logic                 clk_o,
  output logic                 clk_en_o,
  output logic                 rst_o,
  output logic                 div_busy_o,
  output logic [DIV_WIDTH-1:0] div_active_o
);

  localparam logic [DIV_WIDTH-1:0] c_div_min   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] c_div_reset =
      (DEFAULT_DIV < 2) ? c_div_min : DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [15:0]          c_hold_last = 16'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_STOPPING   = 2'd2,
    S_STOPPED    = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_hold_run;
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic [DIV_WIDTH-1:0]   r_pend;
  logic [1:0]             r_rst_sync;
  logic [15:0]            r_hold_cnt;

  state_t                 w_state_n;
  logic                   w_running;
  logic                   w_wrap;
  logic                   w_run_n;
  logic                   w_clk_n;
  logic                   w_en_n;
  logic                   w_busy_n;
  logic                   w_rst_o_n;
  logic [DIV_WIDTH-1:0]   w_cnt_n;
  logic [DIV_WIDTH-1:0]   w_pend_n;
  logic [DIV_WIDTH-1:0]   w_act_n;
  logic [DIV_WIDTH-1:0]   w_load_val;
  logic [15:0]            w_hold_n;

  // During the reset hold the divider may already be generating periods.
  assign w_running  = (r_state == S_RESET_HOLD) ? r_hold_run
                                                : (r_state == S_RUN || r_state == S_STOPPING);
  assign w_wrap     = (r_cnt == div_active_o - 1'b1);
  assign w_load_val = (div_i < c_div_min) ? c_div_min : div_i;

  always_comb begin
    w_cnt_n  = r_cnt;
    w_run_n  = w_running;
    w_act_n  = div_active_o;
    w_pend_n = r_pend;
    w_busy_n = div_busy_o;
    w_clk_n  = clk_o;
    w_en_n   = 1'b0;

    if (w_running) begin
      if (w_wrap) begin
        // Period boundary: the only point a pending divisor may take effect.
        if (div_busy_o)
          w_act_n = r_pend;
        w_busy_n = div_load_i;
        if (div_load_i)
          w_pend_n = w_load_val;
        w_cnt_n = '0;
        w_run_n = enable_i;
        w_clk_n = enable_i;
        w_en_n  = enable_i;
      end else begin
        w_cnt_n = r_cnt + 1'b1;
        w_clk_n = (w_cnt_n < (div_active_o >> 1));
        if (div_load_i) begin
          w_pend_n = w_load_val;
          w_busy_n = 1'b1;
        end
      end
    end else begin
      if (div_load_i)
        w_act_n = w_load_val;
      else if (div_busy_o)
        w_act_n = r_pend;
      w_busy_n = 1'b0;
      w_cnt_n  = '0;
      w_run_n  = enable_i;
      w_clk_n  = enable_i;
      w_en_n   = enable_i;
    end
  end

  always_comb begin
    w_hold_n  = r_hold_cnt;
    w_rst_o_n = rst_o;
    if (rst_o && r_rst_sync[1]) begin
      if (r_hold_cnt == c_hold_last)
        w_rst_o_n = 1'b0;
      else
        w_hold_n = r_hold_cnt + 16'd1;
    end

    if (w_rst_o_n)
      w_state_n = S_RESET_HOLD;
    else if (!w_run_n)
      w_state_n = S_STOPPED;
    else if (enable_i)
      w_state_n = S_RUN;
    else
      w_state_n = S_STOPPING;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RESET_HOLD;
      r_hold_run   <= 1'b0;
      r_cnt        <= '0;
      r_pend       <= '0;
      r_rst_sync   <= 2'b00;
      r_hold_cnt   <= '0;
      clk_o        <= 1'b0;
      clk_en_o     <= 1'b0;
      rst_o        <= 1'b1;
      div_busy_o   <= 1'b0;
      div_active_o <= c_div_reset;
    end else begin
      r_state      <= w_state_n;
      r_hold_run   <= w_run_n;
      r_cnt        <= w_cnt_n;
      r_pend       <= w_pend_n;
      r_rst_sync   <= {r_rst_sync[0], 1'b1};
      r_hold_cnt   <= w_hold_n;
      clk_o        <= w_clk_n;
      clk_en_o     <= w_en_n;
      rst_o        <= w_rst_o_n;
      div_busy_o   <= w_busy_n;
      div_active_o <= w_act_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_divider_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_clk_divider_ctrl: directed vectors plus randomized run against a        |
// | period-level reference model. Revision: 1.0                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_clk_divider_ctrl;

  localparam int c_hold  = 16;
  localparam int c_rel18 = 2 + c_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i;
  logic [7:0] div_i;
  logic       div_load_i;
  logic       clk_o;
  logic       clk_en_o;
  logic       rst_o;
  logic       div_busy_o;
  logic [7:0] div_active_o;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current period and the period length.
  bit m_run;
  int m_cnt;
  int m_div;
  int m_pend;   // 0 means nothing pending
  int m_rel;    // clk edges since reset release

  clk_divider_ctrl #(
    .DIV_WIDTH       (8),
    .DEFAULT_DIV     (2),
    .RST_HOLD_CYCLES (c_hold)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .div_i        (div_i),
    .div_load_i   (div_load_i),
    .clk_o        (clk_o),
    .clk_en_o     (clk_en_o),
    .rst_o        (rst_o),
    .div_busy_o   (div_busy_o),
    .div_active_o (div_active_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void model_reset();
    m_run  = 1'b0;
    m_cnt  = 0;
    m_div  = 2;
    m_pend = 0;
    m_rel  = 0;
  endfunction

  function automatic void model_step(input bit en, input bit ld, input int dv);
    if (m_rel < 100000) m_rel++;
    if (m_run && m_cnt != m_div - 1) begin
      m_cnt++;
      if (ld) m_pend = clampv(dv);
    end else if (m_run) begin
      if (m_pend != 0) m_div = m_pend;
      m_pend = ld ? clampv(dv) : 0;
      m_cnt  = 0;
      m_run  = en;
    end else begin
      if (ld) m_div = clampv(dv);
      else if (m_pend != 0) m_div = m_pend;
      m_pend = 0;
      m_cnt  = 0;
      m_run  = en;
    end
  endfunction

  function automatic bit exp_clk();
    return m_run && (m_cnt < m_div / 2);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_clk_o",    int'(clk_o),        int'(exp_clk()));
    check("model_clk_en_o", int'(clk_en_o),     int'(m_run && m_cnt == 0));
    check("model_busy",     int'(div_busy_o),   int'(m_pend != 0));
    check("model_active",   int'(div_active_o), m_div);
    check("model_rst_o",    int'(rst_o),        int'(m_rel < c_rel18));
  endtask

  // One clk cycle: model consumes the inputs seen at the edge, DUT checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(enable_i, div_load_i, int'(div_i));
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (!(m_run && m_cnt == target) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("wait_cnt_timeout", 0, 1);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (m_pend != 0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("wait_busy_timeout", 0, 1);
  endtask

  task automatic load(input int v);
    div_i      = 8'(v);
    div_load_i = 1'b1;
    tick();
    div_load_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] div;
    int         exp_active;
  } clamp_vec_t;

  clamp_vec_t vecs[6];

  int  exp_clk30 [10];
  int  exp_busy30[10];
  int  exp_act30 [10];
  int  exp_en30  [10];
  bit  seen5;
  int  guard;

  initial begin
    vecs[0] = '{8'd9,   9};
    vecs[1] = '{8'd0,   2};
    vecs[2] = '{8'd5,   5};
    vecs[3] = '{8'd1,   2};
    vecs[4] = '{8'd2,   2};
    vecs[5] = '{8'd255, 255};
    exp_clk30  = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    exp_en30   = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    exp_busy30 = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_act30  = '{4, 4, 7, 7, 7, 7, 7, 7, 7, 7};

    rst        = 1'b1;
    enable_i   = 1'b0;
    div_i      = '0;
    div_load_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_clk_o",  int'(clk_o),        0);
    check("reset_en",     int'(clk_en_o),     0);
    check("reset_rst_o",  int'(rst_o),        1);
    check("reset_busy",   int'(div_busy_o),   0);
    check("reset_active", int'(div_active_o), 2);

    // Default divisor 2 running straight out of reset, reset stretched 2+16 edges.
    enable_i = 1'b1;
    rst      = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i <= 4) check("div2_clk_o", int'(clk_o), i % 2);
      if (i == c_rel18 - 1) check("hold_rst_o_still_high", int'(rst_o), 1);
      if (i == c_rel18)     check("hold_rst_o_released",   int'(rst_o), 0);
    end

    // Clamp table applied while stopped: immediate effect, never busy.
    enable_i = 1'b0;
    guard = 0;
    while (m_run && guard < 400) begin tick(); guard++; end
    foreach (vecs[k]) begin
      load(int'(vecs[k].div));
      check("clamp_active", int'(div_active_o), vecs[k].exp_active);
      check("clamp_busy",   int'(div_busy_o),   0);
    end

    // D=4, load 7 at cnt=1: period completes, then 3 high / 4 low.
    enable_i = 1'b1;
    load(4);
    wait_cnt(1);
    load(7);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      check("sw7_clk_o",  int'(clk_o),        exp_clk30[i]);
      check("sw7_en",     int'(clk_en_o),     exp_en30[i]);
      check("sw7_busy",   int'(div_busy_o),   exp_busy30[i]);
      check("sw7_active", int'(div_active_o), exp_act30[i]);
    end

    // Two loads inside one D=8 period: only the last one is ever applied.
    load(8);
    wait_not_busy();
    wait_cnt(1);
    load(5);
    tick();
    load(9);
    seen5 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (div_active_o == 8'd5) seen5 = 1'b1;
    end
    check("overwrite_seen5",  int'(seen5),        0);
    check("overwrite_active", int'(div_active_o), 9);

    // D=6, stop requested at cnt=1: four more cycles, then parked low.
    load(6);
    wait_not_busy();
    wait_cnt(1);
    enable_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("stop_clk_o", int'(clk_o), (i == 1) ? 1 : 0);
      check("stop_en",    int'(clk_en_o), 0);
    end
    enable_i = 1'b1;
    tick();
    check("restart_clk_o", int'(clk_o),    1);
    check("restart_en",    int'(clk_en_o), 1);
    tick();
    check("restart_en_low", int'(clk_en_o), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) enable_i = ~enable_i;
      div_load_i = ($urandom_range(0, 5) == 0);
      div_i      = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 12));
      tick();
    end
    div_load_i = 1'b0;

    // Reset pulsed mid-hold while clk_o is high.
    enable_i = 1'b1;
    load(5);
    wait_not_busy();
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_active", int'(div_active_o), 2);
    check("async_rst_rst_o",  int'(rst_o),        1);
    @(negedge clk);
    rst = 1'b0;
    guard = 0;
    while (!(m_rel >= 12 && exp_clk()) && guard < 40) begin tick(); guard++; end
    check("midhold_clk_high", int'(clk_o), 1);
    rst = 1'b1;
    #1;
    check("midhold_rst_o",  int'(rst_o),    1);
    check("midhold_clk_o",  int'(clk_o),    0);
    check("midhold_en",     int'(clk_en_o), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= c_rel18; i++) begin
      tick();
      if (i == c_rel18 - 1) check("rehold_rst_o_high", int'(rst_o), 1);
      if (i == c_rel18)     check("rehold_rst_o_low",  int'(rst_o), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
